// File: rtl/tensor_wb_arbiter_pkg.sv
// Shared definitions for the tensor/VALU writeback arbiter: default lane
// geometry, source encoding and the packed payload layout.
package tensor_wb_arbiter_pkg;

    localparam int unsigned NUM_THREAD_DEF = 32'd4;
    localparam int unsigned XLEN_DEF       = 32'd32;
    localparam int unsigned DEPTH_WARP_DEF = 32'd3;
    localparam int unsigned IDXW_DEF       = 32'd8;

    // Source of a writeback entry; also used to remember the last grant.
    typedef enum logic {
        SRC_TENSOR = 1'b0,
        SRC_VALU   = 1'b1
    } src_e;

    // Packed payload layout, LSB first: wid | idx | wvd | mask | data.
    function automatic int unsigned payload_width(input int unsigned nt,
                                                  input int unsigned xlen,
                                                  input int unsigned idxw,
                                                  input int unsigned dw);
        return nt * xlen + nt + 32'd1 + idxw + dw;
    endfunction

    function automatic int unsigned off_wid();
        return 32'd0;
    endfunction

    function automatic int unsigned off_idx(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned off_wvd(input int unsigned idxw,
                                            input int unsigned dw);
        return dw + idxw;
    endfunction

    function automatic int unsigned off_mask(input int unsigned idxw,
                                             input int unsigned dw);
        return dw + idxw + 32'd1;
    endfunction

    function automatic int unsigned off_data(input int unsigned nt,
                                             input int unsigned idxw,
                                             input int unsigned dw);
        return dw + idxw + 32'd1 + nt;
    endfunction

endpackage

// File: rtl/tensor_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// req[0] = tensor, req[1] = VALU; last = 1 means VALU was granted last.
// grant[i] means "port i wins if it requests": it is a function of the
// other port's request and the history only, never of req[i] itself, so
// a ready derived from it cannot depend on the same port's valid.  When
// both ports request, exactly one grant bit is set.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Winner selection: an uncontested port wins, contention goes to the
    // port that did not win last time.
    always_comb begin
        grant    = 2'b00;
        grant[0] = ~req[1] | last;
        grant[1] = ~req[0] | ~last;
    end

endmodule

// File: rtl/tensor_wb_arbiter.sv
// Merges the tensor-unit and VALU result streams into one vector-regfile
// write port.  A single output register holds one entry; it can be loaded
// in the same cycle it drains, so sustained throughput is one entry/cycle.
// Note: the reset input keeps its legacy name rst_n but is active-high.
module tensor_wb_arbiter
    import tensor_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_THREAD = NUM_THREAD_DEF,
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned DEPTH_WARP = DEPTH_WARP_DEF,
    parameter int unsigned IDXW       = IDXW_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       t_valid_i,
    output logic                       t_ready_o,
    input  logic [NUM_THREAD*XLEN-1:0] t_data_i,
    input  logic [NUM_THREAD-1:0]      t_mask_i,
    input  logic                       t_wvd_i,
    input  logic [IDXW-1:0]            t_idx_i,
    input  logic [DEPTH_WARP-1:0]      t_wid_i,

    input  logic                       v_valid_i,
    output logic                       v_ready_o,
    input  logic [NUM_THREAD*XLEN-1:0] v_data_i,
    input  logic [NUM_THREAD-1:0]      v_mask_i,
    input  logic                       v_wvd_i,
    input  logic [IDXW-1:0]            v_idx_i,
    input  logic [DEPTH_WARP-1:0]      v_wid_i,

    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_THREAD*XLEN-1:0] out_data_o,
    output logic [NUM_THREAD-1:0]      out_mask_o,
    output logic                       out_wvd_o,
    output logic [IDXW-1:0]            out_idx_o,
    output logic [DEPTH_WARP-1:0]      out_wid_o,
    output logic                       out_src_o
);

    localparam int unsigned DATA_W    = NUM_THREAD * XLEN;
    localparam int unsigned PAYLOAD_W = payload_width(NUM_THREAD, XLEN, IDXW, DEPTH_WARP);
    localparam int unsigned OFF_WID   = off_wid();
    localparam int unsigned OFF_IDX   = off_idx(DEPTH_WARP);
    localparam int unsigned OFF_WVD   = off_wvd(IDXW, DEPTH_WARP);
    localparam int unsigned OFF_MASK  = off_mask(IDXW, DEPTH_WARP);
    localparam int unsigned OFF_DATA  = off_data(NUM_THREAD, IDXW, DEPTH_WARP);

    logic [PAYLOAD_W-1:0] t_payload_s;
    logic [PAYLOAD_W-1:0] v_payload_s;
    logic [PAYLOAD_W-1:0] load_payload_s;
    logic [PAYLOAD_W-1:0] payload_r;
    logic [1:0]           req_s;
    logic [1:0]           grant_s;
    logic                 free_s;
    logic                 t_ready_s;
    logic                 v_ready_s;
    logic                 xfer_t_s;
    logic                 xfer_v_s;
    logic                 xfer_s;
    logic                 out_valid_r;
    src_e                 out_src_r;
    src_e                 last_grant_r;
    src_e                 load_src_s;

    assign t_payload_s = {t_data_i, t_mask_i, t_wvd_i, t_idx_i, t_wid_i};
    assign v_payload_s = {v_data_i, v_mask_i, v_wvd_i, v_idx_i, v_wid_i};
    assign req_s       = {v_valid_i, t_valid_i};

    rr_arb2 u_rr_arb2 (
        .req   (req_s),
        .last  (last_grant_r),
        .grant (grant_s)
    );

    // Handshake: register may load when empty or draining this cycle;
    // select the payload of whichever port actually transfers.
    always_comb begin
        free_s    = ~out_valid_r | out_ready_i;
        t_ready_s = grant_s[0] & free_s;
        v_ready_s = grant_s[1] & free_s;
        xfer_t_s  = t_valid_i & t_ready_s;
        xfer_v_s  = v_valid_i & v_ready_s;
        xfer_s    = xfer_t_s | xfer_v_s;
        if (xfer_v_s) begin
            load_payload_s = v_payload_s;
            load_src_s     = SRC_VALU;
        end else begin
            load_payload_s = t_payload_s;
            load_src_s     = SRC_TENSOR;
        end
    end

    // Output register and grant history; loading takes priority over
    // draining so a simultaneous drain+load leaves no bubble.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid_r  <= 1'b0;
            out_src_r    <= SRC_TENSOR;
            payload_r    <= {PAYLOAD_W{1'b0}};
            last_grant_r <= SRC_VALU;
        end else if (xfer_s) begin
            out_valid_r  <= 1'b1;
            out_src_r    <= load_src_s;
            payload_r    <= load_payload_s;
            last_grant_r <= load_src_s;
        end else if (out_ready_i) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    assign t_ready_o   = t_ready_s;
    assign v_ready_o   = v_ready_s;
    assign out_valid_o = out_valid_r;
    assign out_src_o   = out_src_r;
    assign out_data_o  = payload_r[OFF_DATA +: DATA_W];
    assign out_mask_o  = payload_r[OFF_MASK +: NUM_THREAD];
    assign out_wvd_o   = payload_r[OFF_WVD];
    assign out_idx_o   = payload_r[OFF_IDX +: IDXW];
    assign out_wid_o   = payload_r[OFF_WID +: DEPTH_WARP];

endmodule

// File: tb/tb_tensor_wb_arbiter.sv
// Self-checking bench for tensor_wb_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_tensor_wb_arbiter;

    localparam int NT = 4;
    localparam int XL = 32;
    localparam int DW = 3;
    localparam int IW = 8;
    localparam int N_RAND = 1000;

    typedef struct packed {
        logic [NT*XL-1:0] data;
        logic [NT-1:0]    mask;
        logic             wvd;
        logic [IW-1:0]    idx;
        logic [DW-1:0]    wid;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             t_valid_i, t_ready_o, t_wvd_i;
    logic [NT*XL-1:0] t_data_i;
    logic [NT-1:0]    t_mask_i;
    logic [IW-1:0]    t_idx_i;
    logic [DW-1:0]    t_wid_i;
    logic             v_valid_i, v_ready_o, v_wvd_i;
    logic [NT*XL-1:0] v_data_i;
    logic [NT-1:0]    v_mask_i;
    logic [IW-1:0]    v_idx_i;
    logic [DW-1:0]    v_wid_i;
    logic             out_valid_o, out_ready_i, out_wvd_o, out_src_o;
    logic [NT*XL-1:0] out_data_o;
    logic [NT-1:0]    out_mask_o;
    logic [IW-1:0]    out_idx_o;
    logic [DW-1:0]    out_wid_o;

    int n_checks = 0;
    int n_errors = 0;

    tensor_wb_arbiter #(
        .NUM_THREAD(NT), .XLEN(XL), .DEPTH_WARP(DW), .IDXW(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .t_valid_i(t_valid_i), .t_ready_o(t_ready_o), .t_data_i(t_data_i),
        .t_mask_i(t_mask_i), .t_wvd_i(t_wvd_i), .t_idx_i(t_idx_i), .t_wid_i(t_wid_i),
        .v_valid_i(v_valid_i), .v_ready_o(v_ready_o), .v_data_i(v_data_i),
        .v_mask_i(v_mask_i), .v_wvd_i(v_wvd_i), .v_idx_i(v_idx_i), .v_wid_i(v_wid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_mask_o(out_mask_o), .out_wvd_o(out_wvd_o), .out_idx_o(out_idx_o),
        .out_wid_o(out_wid_o), .out_src_o(out_src_o)
    );

    always #5 clk = ~clk;

    function automatic ent_t rand_ent();
        ent_t e;
        e.data = {$urandom(), $urandom(), $urandom(), $urandom()};
        e.mask = NT'($urandom());
        e.wvd  = 1'($urandom());
        e.idx  = IW'($urandom());
        e.wid  = DW'($urandom());
        return e;
    endfunction

    function automatic ent_t out_ent();
        return {out_data_o, out_mask_o, out_wvd_o, out_idx_o, out_wid_o};
    endfunction

    task automatic drive_t(input logic vld, input ent_t e);
        t_valid_i = vld; t_data_i = e.data; t_mask_i = e.mask;
        t_wvd_i = e.wvd; t_idx_i = e.idx; t_wid_i = e.wid;
    endtask

    task automatic drive_v(input logic vld, input ent_t e);
        v_valid_i = vld; v_data_i = e.data; v_mask_i = e.mask;
        v_wvd_i = e.wvd; v_idx_i = e.idx; v_wid_i = e.wid;
    endtask

    // Holds reset for two edges with idle inputs; returns just after
    // release, on a falling edge.
    task automatic apply_reset();
        ent_t z;
        z = '0;
        rst_n = 1'b1;
        drive_t(1'b0, z);
        drive_v(1'b0, z);
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (out_valid_o !== 1'b0) begin
                n_errors++; $display("FAIL reset_valid cyc %0d: got %b want 0", i, out_valid_o);
            end
            n_checks++;
            if (out_src_o !== 1'b0) begin
                n_errors++; $display("FAIL reset_src cyc %0d: got %b want 0", i, out_src_o);
            end
            n_checks++;
            if (out_ent() !== ent_t'(0)) begin
                n_errors++; $display("FAIL reset_payload cyc %0d: got %h want 0", i, out_ent());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        ent_t e, z;
        z = '0;
        e = rand_ent();
        e.idx = 8'h12;
        e.wid = 3'd3;
        drive_t(1'b1, e);
        drive_v(1'b0, z);
        out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (t_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL single_tready: got %b want 1", t_ready_o);
        end
        @(negedge clk);
        drive_t(1'b0, z);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b1 || out_src_o !== 1'b0) begin
            n_errors++; $display("FAIL single_valid_src: got %b/%b want 1/0", out_valid_o, out_src_o);
        end
        n_checks++;
        if (out_idx_o !== 8'h12 || out_wid_o !== 3'd3) begin
            n_errors++; $display("FAIL single_idx_wid: got %h/%0d want 12/3", out_idx_o, out_wid_o);
        end
        n_checks++;
        if (out_ent() !== e) begin
            n_errors++; $display("FAIL single_payload: got %h want %h", out_ent(), e);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL single_drain: got %b want 0", out_valid_o);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        ent_t et, ev, z;
        logic exp_src;
        z = '0;
        et = rand_ent(); et.idx = 8'h01;
        ev = rand_ent(); ev.idx = 8'h02;
        apply_reset();
        out_ready_i = 1'b1;
        drive_t(1'b1, et);
        drive_v(1'b1, ev);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            exp_src = (i % 2 == 1);
            n_checks++;
            if (out_valid_o !== 1'b1 || out_src_o !== exp_src) begin
                n_errors++;
                $display("FAIL rr_src cyc %0d: got valid %b src %b want valid 1 src %b",
                         i, out_valid_o, out_src_o, exp_src);
            end
            n_checks++;
            if (out_ent() !== (exp_src ? ev : et)) begin
                n_errors++; $display("FAIL rr_payload cyc %0d: got %h want %h",
                                     i, out_ent(), exp_src ? ev : et);
            end
        end
        drive_t(1'b0, z);
        drive_v(1'b0, z);
        @(negedge clk);
    endtask

    task automatic test_hold();
        ent_t a, b, c, z;
        z = '0;
        a = rand_ent(); b = rand_ent(); c = rand_ent();
        // Register is empty and VALU won last, so tensor loads freely.
        drive_t(1'b1, a);
        drive_v(1'b0, z);
        out_ready_i = 1'b0;
        @(negedge clk);
        drive_t(1'b1, b);
        drive_v(1'b1, c);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (out_valid_o !== 1'b1 || out_ent() !== a) begin
                n_errors++; $display("FAIL hold_stable cyc %0d: got %b/%h want 1/%h",
                                     k, out_valid_o, out_ent(), a);
            end
            n_checks++;
            if (t_ready_o !== 1'b0 || v_ready_o !== 1'b0) begin
                n_errors++; $display("FAIL hold_ready cyc %0d: got t %b v %b want 0 0",
                                     k, t_ready_o, v_ready_o);
            end
            @(negedge clk);
        end
        out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (v_ready_o !== 1'b1 || t_ready_o !== 1'b0) begin
            n_errors++; $display("FAIL hold_release_ready: got t %b v %b want 0 1", t_ready_o, v_ready_o);
        end
        @(negedge clk);
        drive_t(1'b0, z);
        drive_v(1'b0, z);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b1 || out_src_o !== 1'b1 || out_ent() !== c) begin
            n_errors++; $display("FAIL hold_no_bubble: got %b/%b/%h want 1/1/%h",
                                 out_valid_o, out_src_o, out_ent(), c);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ent_t a, a2, c2, z;
        z = '0;
        a = rand_ent(); a2 = rand_ent(); c2 = rand_ent();
        drive_t(1'b1, a);
        drive_v(1'b0, z);
        out_ready_i = 1'b0;
        @(negedge clk);
        drive_t(1'b0, z);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b1) begin
            n_errors++; $display("FAIL mid_loaded: got %b want 1", out_valid_o);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || out_ent() !== ent_t'(0)) begin
            n_errors++; $display("FAIL mid_async_clear: got %b/%h want 0/0", out_valid_o, out_ent());
        end
        @(negedge clk);
        rst_n = 1'b0;
        drive_t(1'b1, a2);
        drive_v(1'b1, c2);
        out_ready_i = 1'b1;
        @(negedge clk);
        drive_t(1'b0, z);
        drive_v(1'b0, z);
        #1;
        n_checks++;
        if (out_valid_o !== 1'b1 || out_src_o !== 1'b0 || out_ent() !== a2) begin
            n_errors++; $display("FAIL mid_first_grant: got %b/%b/%h want 1/0/%h",
                                 out_valid_o, out_src_o, out_ent(), a2);
        end
        @(negedge clk);
    endtask

    // Random traffic against a transaction model: one held entry, a
    // remembered last winner, and per-port queues of accepted entries.
    task automatic test_random();
        ent_t tq[$];
        ent_t vq[$];
        ent_t t_cur, v_cur, m_ent, exp_e;
        logic m_valid, m_src, m_last;
        logic tv, vv, rdy, free, exp_tr, exp_vr;
        int t_sent, v_sent, t_got, v_got, cyc;
        m_valid = 1'b0; m_src = 1'b0; m_last = 1'b1; m_ent = '0;
        t_sent = 0; v_sent = 0; t_got = 0; v_got = 0; cyc = 0;
        apply_reset();
        t_cur = rand_ent();
        v_cur = rand_ent();
        while (!(t_sent == N_RAND && v_sent == N_RAND && !m_valid) && cyc < 20000) begin
            tv  = (t_sent < N_RAND) && ($urandom_range(0, 3) != 0);
            vv  = (v_sent < N_RAND) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            drive_t(tv, t_cur);
            drive_v(vv, v_cur);
            out_ready_i = rdy;
            #1;
            n_checks++;
            if (out_valid_o !== m_valid) begin
                n_errors++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, out_valid_o, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if (out_ent() !== m_ent || out_src_o !== m_src) begin
                    n_errors++; $display("FAIL rand_entry cyc %0d: got %b/%h want %b/%h",
                                         cyc, out_src_o, out_ent(), m_src, m_ent);
                end
            end
            free   = !m_valid || rdy;
            exp_tr = free && (!vv || m_last);
            exp_vr = free && (!tv || !m_last);
            n_checks++;
            if (t_ready_o !== exp_tr || v_ready_o !== exp_vr) begin
                n_errors++; $display("FAIL rand_ready cyc %0d: got t %b v %b want t %b v %b",
                                     cyc, t_ready_o, v_ready_o, exp_tr, exp_vr);
            end
            if (m_valid && rdy) begin
                n_checks++;
                if (m_src == 1'b0 ? tq.size() == 0 : vq.size() == 0) begin
                    n_errors++; $display("FAIL rand_scoreboard cyc %0d: drain with empty queue src %b", cyc, m_src);
                end else begin
                    if (m_src == 1'b0) begin exp_e = tq.pop_front(); t_got++; end
                    else begin exp_e = vq.pop_front(); v_got++; end
                    if (out_ent() !== exp_e) begin
                        n_errors++; $display("FAIL rand_scoreboard cyc %0d: got %h want %h", cyc, out_ent(), exp_e);
                    end
                end
            end
            if (tv && exp_tr) begin
                m_ent = t_cur; m_src = 1'b0; m_last = 1'b0; m_valid = 1'b1;
                tq.push_back(t_cur); t_sent++; t_cur = rand_ent();
            end else if (vv && exp_vr) begin
                m_ent = v_cur; m_src = 1'b1; m_last = 1'b1; m_valid = 1'b1;
                vq.push_back(v_cur); v_sent++; v_cur = rand_ent();
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 20000) begin
            n_errors++; $display("FAIL rand_timeout: got %0d cycles want < 20000", cyc);
        end
        n_checks++;
        if (t_got != N_RAND || v_got != N_RAND) begin
            n_errors++; $display("FAIL rand_counts: got t %0d v %0d want %0d each", t_got, v_got, N_RAND);
        end
        n_checks++;
        if (tq.size() != 0 || vq.size() != 0) begin
            n_errors++; $display("FAIL rand_leftover: got t %0d v %0d want 0 0", tq.size(), vq.size());
        end
        drive_t(1'b0, t_cur);
        drive_v(1'b0, v_cur);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
